uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop sync, oversampled majority vote, start/stop validation.
// Latency: ~2 sync cycles + 9.5 bit periods from the falling start edge to data_valid.
// Backpressure: one-entry output register; a new byte arriving while it is still full is dropped with overrun_err.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_V0      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1      = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2      = SW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [1:0]      v_q, v_d;
    logic            bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            deliver_q, deliver_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_err_q, overrun_err_d;

    logic tick, sample_mid, bit_end, maj;

    // Sample strobes and the three-sample majority (third sample is the live rx_s)
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        sample_mid = tick && (s_q == S_V2);
        bit_end    = tick && (s_q == S_LAST);
        maj        = (v_q[0] & v_q[1]) | (v_q[0] & rx_s_q) | (v_q[1] & rx_s_q);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            tick_cnt_q    <= '0;
            s_q           <= '0;
            bit_cnt_q     <= '0;
            v_q           <= '0;
            bit_q         <= 1'b0;
            shift_q       <= '0;
            deliver_q     <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            tick_cnt_q    <= tick_cnt_d;
            s_q           <= s_d;
            bit_cnt_q     <= bit_cnt_d;
            v_q           <= v_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            deliver_q     <= deliver_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    // Next-state logic; BREAK holds off new starts until the line returns high
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s_q) state_d = START;
            START: begin
                if (sample_mid && maj) state_d = IDLE;
                else if (bit_end)      state_d = DATA;
            end
            DATA:  if (bit_end && (bit_cnt_q == 3'd7)) state_d = STOP;
            STOP:  if (sample_mid) state_d = maj ? IDLE : BREAK;
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sampling, shifting, stop-bit outcome and output register handshake
    always_comb begin
        rx_meta_d     = rx;
        rx_s_d        = rx_meta_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + CW'(1);
        s_d           = s_q;
        bit_cnt_d     = bit_cnt_q;
        v_d           = v_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        deliver_d     = 1'b0;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;

        if (state_q == IDLE) begin
            s_d       = '0;
            bit_cnt_d = '0;
            // Align the sample grid to the detected falling edge
            if (state_d == START) tick_cnt_d = '0;
        end else if (tick) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
            if (s_q == S_V0) v_d[0] = rx_s_q;
            if (s_q == S_V1) v_d[1] = rx_s_q;
            if (s_q == S_V2) bit_d  = maj;
        end

        if ((state_q == DATA) && bit_end) begin
            shift_d   = {bit_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if ((state_q == STOP) && sample_mid) begin
            if (maj) deliver_d   = 1'b1;
            else     frame_err_d = 1'b1;
        end

        if (data_valid_q && data_ready) data_valid_d = 1'b0;
        if (deliver_q) begin
            if (!data_valid_q || data_ready) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end
    end

    // Output drive
    always_comb begin
        busy        = (state_q != IDLE);
        data_out    = data_out_q;
        data_valid  = data_valid_q;
        frame_err   = frame_err_q;
        overrun_err = overrun_err_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 160 clocks per nominal bit.
// Bytes expected to be delivered go into exp_q; the monitor captures accepted bytes into got_q.
// Error pulses and data_valid cycles are counted by the monitor and checked as deltas per scenario.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int dv_cycles = 0;
    int fe_cnt    = 0;
    int ov_cnt    = 0;
    int stab_viol = 0;

    logic [7:0] prev_out;
    logic       prev_valid;
    logic       prev_ready;

    uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUDRATE  (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge: capture accepted bytes, count pulses, watch output stability
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (data_valid) dv_cycles++;
            if (data_valid && data_ready) got_q.push_back(data_out);
            if (frame_err) fe_cnt++;
            if (overrun_err) ov_cnt++;
            if (data_valid && prev_valid && !prev_ready && (data_out !== prev_out)) stab_viol++;
        end
        prev_out   = data_out;
        prev_valid = data_valid;
        prev_ready = data_ready;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        cyc(n);
    endtask

    // glitch_bit >= 0 inverts a 10-clock window around the middle sample of that data bit
    task automatic send_byte(input logic [7:0] b, input int bitclks, input logic stop_bit, input int glitch_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (glitch_bit >= 0 && i == glitch_bit + 1) begin
                rx = frame[i];  cyc(88);
                rx = ~frame[i]; cyc(10);
                rx = frame[i];  cyc(bitclks - 98);
            end else begin
                rx = frame[i];
                cyc(bitclks);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx = 1'b1; data_ready = 1'b0;
        cyc(5);
        @(negedge clk);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        cyc(1);
        rst_n = 1'b1;
        idle(20);
    endtask

    task automatic test_basic;
        int dv0, fe0, ov0;
        logic [7:0] e, g;
        data_ready = 1'b1;
        dv0 = dv_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'h23);
        send_byte(8'h23, 160, 1'b1, -1);
        idle(40);
        @(negedge clk);
        n_checks++; if (dv_cycles - dv0 != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", dv_cycles - dv0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL basic_byte: none received, want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL basic_byte: got %h want %h", g, e); end end
        end
        n_checks++; if (fe_cnt - fe0 + ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL basic_errors: got %0d pulses want 0", fe_cnt - fe0 + ov_cnt - ov0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int ov0;
        logic [7:0] e, g;
        data_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h51);
        send_byte(8'h51, 160, 1'b1, -1);
        send_byte(8'hA5, 160, 1'b1, -1);
        idle(40);
        @(negedge clk);
        n_checks++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL bp_overrun: got %0d pulses want 1", ov_cnt - ov0); end
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", data_valid); end
        n_checks++; if (data_out !== 8'h51) begin n_fail++; $display("FAIL bp_data_held: got %h want 51", data_out); end
        n_checks++; if (stab_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stab_viol); end
        cyc(1);
        data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", data_valid); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL bp_byte: none received, want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL bp_byte: got %h want %h", g, e); end end
        end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra bytes want 0", got_q.size()); end
        cyc(1);
    endtask

    task automatic test_noise;
        int dv0;
        logic [7:0] e, g;
        data_ready = 1'b1;
        dv0 = dv_cycles;
        rx = 1'b0; cyc(30);
        rx = 1'b1;
        for (int k = 0; k < 400 && busy; k++) cyc(1);
        idle(20);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b want 0", busy); end
        n_checks++; if (dv_cycles - dv0 != 0 || got_q.size() != 0) begin n_fail++; $display("FAIL glitch_no_data: got %0d valid cycles want 0", dv_cycles - dv0); end
        exp_q.push_back(8'h00);
        send_byte(8'h00, 160, 1'b1, 3);
        idle(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL spike_byte: none received, want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL spike_byte: got %h want %h", g, e); end end
        end
    endtask

    task automatic test_framing;
        int dv0, fe0;
        logic [7:0] e, g;
        data_ready = 1'b1;
        dv0 = dv_cycles; fe0 = fe_cnt;
        send_byte(8'h7E, 160, 1'b0, -1);
        rx = 1'b0; cyc(320);
        idle(50);
        @(negedge clk);
        n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d want 1", fe_cnt - fe0); end
        n_checks++; if (dv_cycles - dv0 != 0) begin n_fail++; $display("FAIL frame_no_data: got %0d valid cycles want 0", dv_cycles - dv0); end
        exp_q.push_back(8'h01);
        send_byte(8'h01, 160, 1'b1, -1);
        idle(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL frame_next_byte: none received, want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL frame_next_byte: got %h want %h", g, e); end end
        end
        n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL frame_err_total: got %0d want 1", fe_cnt - fe0); end
    endtask

    task automatic test_reset_midframe;
        int fe0, ov0, dv0;
        logic [9:0] frame;
        logic [7:0] e, g;
        data_ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; dv0 = dv_cycles;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 5; i++) begin rx = frame[i]; cyc(160); end
        rx = frame[5]; cyc(80);
        rst_n = 1'b0; rx = 1'b1;
        cyc(2);
        @(negedge clk);
        n_checks++; if ({data_out, data_valid, frame_err, overrun_err, busy} !== 12'h000) begin
            n_fail++; $display("FAIL midreset_outputs: got data_out=%h valid=%b fe=%b ov=%b busy=%b want all 0",
                              data_out, data_valid, frame_err, overrun_err, busy);
        end
        cyc(3);
        rst_n = 1'b1;
        idle(320);
        @(negedge clk);
        n_checks++; if (fe_cnt - fe0 + ov_cnt - ov0 + dv_cycles - dv0 != 0) begin
            n_fail++; $display("FAIL midreset_quiet: got %0d events want 0", fe_cnt - fe0 + ov_cnt - ov0 + dv_cycles - dv0);
        end
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 160, 1'b1, -1);
        idle(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL midreset_byte: none received, want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL midreset_byte: got %h want %h", g, e); end end
        end
    endtask

    task automatic test_baud_mismatch;
        int fe0, ov0;
        logic [7:0] e, g;
        data_ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'h96);
        send_byte(8'h96, 165, 1'b1, -1);
        idle(40);
        exp_q.push_back(8'h69);
        send_byte(8'h69, 155, 1'b1, -1);
        idle(60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL baud_byte: none received, want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL baud_byte: got %h want %h", g, e); end end
        end
        n_checks++; if (fe_cnt - fe0 + ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL baud_errors: got %0d pulses want 0", fe_cnt - fe0 + ov_cnt - ov0); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL baud_extra: got %0d extra bytes want 0", got_q.size()); end
    endtask

    initial begin
        rst_n      = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_noise;
        test_framing;
        test_reset_midframe;
        test_baud_mismatch;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
